// File: rtl/i2c_slave_memory_bank_pkg.sv
// Shared encodings for the I2C slave memory bank: FSM states, command field
// encodings and the byte returned when a read finds an empty buffer.
package i2c_slave_pkg;

    typedef enum logic {
        IDLE     = 1'b0,
        SELECTED = 1'b1
    } state_t;

    localparam logic MODE_MATCH = 1'b0;
    localparam logic MODE_DATA  = 1'b1;

    localparam logic RORW_READ  = 1'b0;
    localparam logic RORW_WRITE = 1'b1;

    localparam logic [7:0] EMPTY_READ = 8'hFF;

    // Width of an address index; a single address still gets one bit.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/i2c_slave_memory_bank_if.sv
// Command/response bundle between the bus front-end and the memory bank.
interface i2c_slave_memory_bank_if
    import i2c_slave_pkg::*;
#(
    parameter int ADDRESSLENGTH = 8,
    parameter int ADDRESSNUM    = 4
);
    logic [ADDRESSLENGTH*ADDRESSNUM-1:0] AddressList;
    logic [ADDRESSLENGTH-1:0]            DirectionBuffer;
    logic                                Enable;
    logic                                Mode;
    logic                                RorW;
    logic [7:0]                          InputBuffer;
    logic [7:0]                          OutputBuffer;
    logic                                AddressFound;
    logic [id_width(ADDRESSNUM)-1:0]     LocalAddressID;
    logic                                Done;
    logic                                Overflow;
    logic                                Underflow;
    logic                                AccessError;

    modport master (
        output AddressList, DirectionBuffer, Enable, Mode, RorW, InputBuffer,
        input  OutputBuffer, AddressFound, LocalAddressID, Done,
               Overflow, Underflow, AccessError
    );

    modport slave (
        input  AddressList, DirectionBuffer, Enable, Mode, RorW, InputBuffer,
        output OutputBuffer, AddressFound, LocalAddressID, Done,
               Overflow, Underflow, AccessError
    );
endinterface

// File: rtl/i2c_slave_memory_bank_fifo.sv
// Byte FIFO owned by one slave address. A write to a full FIFO is dropped,
// or with WRAP set replaces the oldest byte. The caller never requests a
// read and a write in the same cycle.
module i2c_byte_fifo #(
    parameter int NBYTES = 4,
    parameter int WRAP   = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_en,
    input  logic       rd_en,
    input  logic [7:0] wr_data,
    output logic [7:0] rd_data,
    output logic       full,
    output logic       empty
);
    localparam int PW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    logic [7:0]    mem [NBYTES];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic          do_write;
    logic          do_read;

    assign full     = (count == (PW+1)'(NBYTES));
    assign empty    = (count == '0);
    assign rd_data  = mem[rd_ptr];
    assign do_write = wr_en && (!full || (WRAP != 0));
    assign do_read  = rd_en && !empty;

    // Storage array; contents survive reset, only the pointers are cleared.
    always_ff @(posedge clk) begin
        if (rst_n && do_write) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers and fill count; a wrapping write to a full FIFO drags the read pointer along.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (do_write) begin
            wr_ptr <= wr_ptr + PW'(1);
            if (full) begin
                rd_ptr <= rd_ptr + PW'(1);
            end else begin
                count <= count + (PW+1)'(1);
            end
        end else if (do_read) begin
            rd_ptr <= rd_ptr + PW'(1);
            count  <= count - (PW+1)'(1);
        end
    end
endmodule

// File: rtl/i2c_slave_memory_bank.sv
// I2C slave memory bank: matches a received address against a list of local
// addresses and gives each one a private byte FIFO for reads and writes.
// Commands fire on the rising edge of Enable; results land one clock later.
module i2c_slave_memory_bank
    import i2c_slave_pkg::*;
#(
    parameter int ADDRESSLENGTH = 8,
    parameter int ADDRESSNUM    = 4,
    parameter int NBYTES        = 4,
    parameter int WRAP          = 0
) (
    input  logic                  Clk,
    input  logic                  Rst_n,
    i2c_slave_memory_bank_if.slave bus
);
    localparam int IDW = id_width(ADDRESSNUM);

    state_t                  state, state_n;
    logic [IDW-1:0]          sel_id, sel_id_n;
    logic [7:0]              out_q, out_n;
    logic                    done_q, done_n;
    logic                    ovf_q, ovf_n;
    logic                    unf_q, unf_n;
    logic                    acc_q, acc_n;
    logic                    enable_q;
    logic                    armed;
    logic                    cmd;
    logic                    hit;
    logic [IDW-1:0]          hit_id;
    logic                    wr_req;
    logic                    rd_req;
    logic [7:0]              fifo_data [ADDRESSNUM];
    logic [ADDRESSNUM-1:0]   fifo_full;
    logic [ADDRESSNUM-1:0]   fifo_empty;
    logic [ADDRESSNUM-1:0]   fifo_wr;
    logic [ADDRESSNUM-1:0]   fifo_rd;

    // armed stays low while an Enable held through reset is still high, so
    // that level is not mistaken for a fresh command after release.
    assign cmd = bus.Enable && !enable_q && armed;

    // Enable edge detector.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            enable_q <= 1'b0;
            armed    <= !bus.Enable;
        end else begin
            enable_q <= bus.Enable;
            armed    <= armed || !bus.Enable;
        end
    end

    // Address lookup; scanning downward lets the lowest matching index win.
    always_comb begin
        hit    = 1'b0;
        hit_id = '0;
        for (int i = ADDRESSNUM - 1; i >= 0; i--) begin
            if (bus.AddressList[i*ADDRESSLENGTH +: ADDRESSLENGTH] == bus.DirectionBuffer) begin
                hit    = 1'b1;
                hit_id = IDW'(i);
            end
        end
    end

    // Command decode: next state, next registered outputs and FIFO requests.
    always_comb begin
        state_n  = state;
        sel_id_n = sel_id;
        out_n    = out_q;
        done_n   = 1'b0;
        ovf_n    = 1'b0;
        unf_n    = 1'b0;
        acc_n    = 1'b0;
        wr_req   = 1'b0;
        rd_req   = 1'b0;
        if (cmd) begin
            done_n = 1'b1;
            if (bus.Mode == MODE_MATCH) begin
                state_n  = hit ? SELECTED : IDLE;
                sel_id_n = hit ? hit_id : '0;
            end else if (state == IDLE) begin
                acc_n = 1'b1;
            end else if (bus.RorW == RORW_WRITE) begin
                wr_req = 1'b1;
                ovf_n  = fifo_full[sel_id];
            end else if (fifo_empty[sel_id]) begin
                out_n = EMPTY_READ;
                unf_n = 1'b1;
            end else begin
                rd_req = 1'b1;
                out_n  = fifo_data[sel_id];
            end
        end
    end

    // Route requests to the selected FIFO; a command caught by reset never reaches storage.
    always_comb begin
        fifo_wr = '0;
        fifo_rd = '0;
        for (int i = 0; i < ADDRESSNUM; i++) begin
            fifo_wr[i] = wr_req && Rst_n && (sel_id == IDW'(i));
            fifo_rd[i] = rd_req && Rst_n && (sel_id == IDW'(i));
        end
    end

    // State and result registers.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state  <= IDLE;
            sel_id <= '0;
            out_q  <= 8'h00;
            done_q <= 1'b0;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
            acc_q  <= 1'b0;
        end else begin
            state  <= state_n;
            sel_id <= sel_id_n;
            out_q  <= out_n;
            done_q <= done_n;
            ovf_q  <= ovf_n;
            unf_q  <= unf_n;
            acc_q  <= acc_n;
        end
    end

    for (genvar g = 0; g < ADDRESSNUM; g++) begin : g_fifo
        i2c_byte_fifo #(
            .NBYTES (NBYTES),
            .WRAP   (WRAP)
        ) u_fifo (
            .clk     (Clk),
            .rst_n   (Rst_n),
            .wr_en   (fifo_wr[g]),
            .rd_en   (fifo_rd[g]),
            .wr_data (bus.InputBuffer),
            .rd_data (fifo_data[g]),
            .full    (fifo_full[g]),
            .empty   (fifo_empty[g])
        );
    end

    assign bus.AddressFound   = (state == SELECTED);
    assign bus.LocalAddressID = sel_id;
    assign bus.OutputBuffer   = out_q;
    assign bus.Done           = done_q;
    assign bus.Overflow       = ovf_q;
    assign bus.Underflow      = unf_q;
    assign bus.AccessError    = acc_q;
endmodule

// File: tb/tb_i2c_slave_memory_bank.sv
// Bench for i2c_slave_memory_bank: one WRAP=0 and one WRAP=1 instance share
// the same command stream; each command pushes its expected response per
// instance and a negedge monitor pops and compares whenever Done pulses.
module tb_i2c_slave_memory_bank;
    import i2c_slave_pkg::*;

    typedef struct {
        logic       found;
        logic [1:0] id;
        logic [7:0] out;
        logic       ovf;
        logic       unf;
        logic       acc;
        int         due;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    exp_t q0[$];
    exp_t q1[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    i2c_slave_memory_bank_if #(.ADDRESSLENGTH(8), .ADDRESSNUM(4)) b0 ();
    i2c_slave_memory_bank_if #(.ADDRESSLENGTH(8), .ADDRESSNUM(4)) b1 ();

    assign b1.AddressList     = b0.AddressList;
    assign b1.DirectionBuffer = b0.DirectionBuffer;
    assign b1.Enable          = b0.Enable;
    assign b1.Mode            = b0.Mode;
    assign b1.RorW            = b0.RorW;
    assign b1.InputBuffer     = b0.InputBuffer;

    i2c_slave_memory_bank #(.ADDRESSLENGTH(8), .ADDRESSNUM(4), .NBYTES(4), .WRAP(0)) dut0 (
        .Clk   (clk),
        .Rst_n (rst_n),
        .bus   (b0)
    );

    i2c_slave_memory_bank #(.ADDRESSLENGTH(8), .ADDRESSNUM(4), .NBYTES(4), .WRAP(1)) dut1 (
        .Clk   (clk),
        .Rst_n (rst_n),
        .bus   (b1)
    );

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic exp_t mk(input logic f, input logic [1:0] id, input logic [7:0] o,
                                input logic ov, input logic un, input logic ac);
        exp_t e;
        e.found = f;
        e.id    = id;
        e.out   = o;
        e.ovf   = ov;
        e.unf   = un;
        e.acc   = ac;
        e.due   = 0;
        return e;
    endfunction

    task automatic observe(input int which, input logic done, input logic found,
                           input logic [1:0] id, input logic [7:0] out,
                           input logic ovf, input logic unf, input logic acc);
        exp_t  e;
        string p;
        p = $sformatf("dut%0d", which);
        if (!done) begin
            check({p, "_stray_pulse"}, {ovf, unf, acc}, 0);
        end else if ((which == 0 && q0.size() == 0) || (which == 1 && q1.size() == 0)) begin
            checks++;
            errors++;
            $display("FAIL %s_unexpected_done: got Done=1, expected no Done (cycle %0d)", p, cyc);
        end else begin
            if (which == 0) e = q0.pop_front();
            else            e = q1.pop_front();
            check({p, "_done_cycle"}, cyc, e.due);
            check({p, "_found"}, found, e.found);
            check({p, "_id"}, id, e.id);
            check({p, "_out"}, out, e.out);
            check({p, "_overflow"}, ovf, e.ovf);
            check({p, "_underflow"}, unf, e.unf);
            check({p, "_access_error"}, acc, e.acc);
        end
    endtask

    // Response monitor, sampling away from the active edge.
    always @(negedge clk) begin
        observe(0, b0.Done, b0.AddressFound, b0.LocalAddressID, b0.OutputBuffer,
                b0.Overflow, b0.Underflow, b0.AccessError);
        observe(1, b1.Done, b1.AddressFound, b1.LocalAddressID, b1.OutputBuffer,
                b1.Overflow, b1.Underflow, b1.AccessError);
    end

    // Called just after a negedge with Enable low; returns likewise.
    task automatic issue(input logic mode, input logic rorw, input logic [7:0] dir,
                         input logic [7:0] din, input exp_t x0, input exp_t x1,
                         input int hold = 1);
        b0.Mode            = mode;
        b0.RorW            = rorw;
        b0.DirectionBuffer = dir;
        b0.InputBuffer     = din;
        b0.Enable          = 1'b1;
        x0.due = cyc + 1;
        x1.due = cyc + 1;
        q0.push_back(x0);
        q1.push_back(x1);
        repeat (hold) @(negedge clk);
        b0.Enable = 1'b0;
        @(negedge clk);
    endtask

    task automatic match(input logic [7:0] dir, input exp_t x, input int hold = 1);
        issue(MODE_MATCH, RORW_READ, dir, 8'h00, x, x, hold);
    endtask

    task automatic wr(input logic [7:0] d, input exp_t x);
        issue(MODE_DATA, RORW_WRITE, 8'h00, d, x, x);
    endtask

    task automatic rd(input exp_t x0, input exp_t x1);
        issue(MODE_DATA, RORW_READ, 8'h00, 8'h00, x0, x1);
    endtask

    task automatic reset_state(input string tag);
        check({tag, "_dut0_found"}, b0.AddressFound, 0);
        check({tag, "_dut0_id"}, b0.LocalAddressID, 0);
        check({tag, "_dut0_out"}, b0.OutputBuffer, 0);
        check({tag, "_dut0_done"}, b0.Done, 0);
        check({tag, "_dut1_found"}, b1.AddressFound, 0);
        check({tag, "_dut1_out"}, b1.OutputBuffer, 0);
    endtask

    logic [7:0] wrap0 [4] = '{8'h01, 8'h02, 8'h03, 8'h04};
    logic [7:0] wrap1 [4] = '{8'h02, 8'h03, 8'h04, 8'h05};

    initial begin
        b0.AddressList     = {8'h40, 8'h33, 8'h0F, 8'hF3};
        b0.DirectionBuffer = 8'h00;
        b0.Enable          = 1'b0;
        b0.Mode            = MODE_MATCH;
        b0.RorW            = RORW_READ;
        b0.InputBuffer     = 8'h00;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        reset_state("reset");

        // Address matching, miss then hit.
        match(8'h2F, mk(0, 2'd0, 8'h00, 0, 0, 0));
        match(8'h0F, mk(1, 2'd1, 8'h00, 0, 0, 0));

        // Write two bytes, reselect, read them back, then underflow.
        wr(8'h55, mk(1, 2'd1, 8'h00, 0, 0, 0));
        wr(8'hF5, mk(1, 2'd1, 8'h00, 0, 0, 0));
        match(8'h0F, mk(1, 2'd1, 8'h00, 0, 0, 0));
        rd(mk(1, 2'd1, 8'h55, 0, 0, 0), mk(1, 2'd1, 8'h55, 0, 0, 0));
        rd(mk(1, 2'd1, 8'hF5, 0, 0, 0), mk(1, 2'd1, 8'hF5, 0, 0, 0));
        rd(mk(1, 2'd1, 8'hFF, 0, 1, 0), mk(1, 2'd1, 8'hFF, 0, 1, 0));

        // Fill address 2 past capacity: drop on WRAP=0, overwrite oldest on WRAP=1.
        match(8'h33, mk(1, 2'd2, 8'hFF, 0, 0, 0));
        for (int i = 1; i <= 4; i++) wr(8'(i), mk(1, 2'd2, 8'hFF, 0, 0, 0));
        wr(8'h05, mk(1, 2'd2, 8'hFF, 1, 0, 0));
        for (int i = 0; i < 4; i++)
            rd(mk(1, 2'd2, wrap0[i], 0, 0, 0), mk(1, 2'd2, wrap1[i], 0, 0, 0));
        rd(mk(1, 2'd2, 8'hFF, 0, 1, 0), mk(1, 2'd2, 8'hFF, 0, 1, 0));

        // Storage persists across reselection.
        match(8'h40, mk(1, 2'd3, 8'hFF, 0, 0, 0));
        wr(8'h77, mk(1, 2'd3, 8'hFF, 0, 0, 0));
        match(8'h33, mk(1, 2'd2, 8'hFF, 0, 0, 0));
        match(8'h40, mk(1, 2'd3, 8'hFF, 0, 0, 0));
        rd(mk(1, 2'd3, 8'h77, 0, 0, 0), mk(1, 2'd3, 8'h77, 0, 0, 0));

        // Data commands with nothing selected are rejected and store nothing.
        match(8'h2F, mk(0, 2'd0, 8'h77, 0, 0, 0));
        wr(8'hAA, mk(0, 2'd0, 8'h77, 0, 0, 1));
        rd(mk(0, 2'd0, 8'h77, 0, 0, 1), mk(0, 2'd0, 8'h77, 0, 0, 1));
        match(8'h40, mk(1, 2'd3, 8'h77, 0, 0, 0));
        rd(mk(1, 2'd3, 8'hFF, 0, 1, 0), mk(1, 2'd3, 8'hFF, 0, 1, 0));
        match(8'hF3, mk(1, 2'd0, 8'hFF, 0, 0, 0));

        // Enable held high for ten cycles acts once.
        match(8'h0F, mk(1, 2'd1, 8'hFF, 0, 0, 0), 10);
        wr(8'h12, mk(1, 2'd1, 8'hFF, 0, 0, 0));

        // Reset lands on a write command; Enable stays high through release.
        b0.Mode        = MODE_DATA;
        b0.RorW        = RORW_WRITE;
        b0.InputBuffer = 8'h34;
        b0.Enable      = 1'b1;
        rst_n          = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        reset_state("mid_reset");
        b0.Enable = 1'b0;
        @(negedge clk);
        match(8'h0F, mk(1, 2'd1, 8'h00, 0, 0, 0));
        rd(mk(1, 2'd1, 8'hFF, 0, 1, 0), mk(1, 2'd1, 8'hFF, 0, 1, 0));

        repeat (3) @(negedge clk);
        check("dut0_pending_responses", q0.size(), 0);
        check("dut1_pending_responses", q1.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
